// File: rtl/branch_resolve.sv
// Execute-stage branch/jump resolution: taken decode, registered redirect, flush squash window
// and saturating branch/taken statistics.
module branch_resolve #(
    parameter int SQUASH_CYC = 1,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_valid,
    input  logic             ex_is_branch,
    input  logic             ex_is_jal,
    input  logic             ex_is_jalr,
    input  logic [2:0]       ex_funct3,
    input  logic [31:0]      ex_pc,
    input  logic [31:0]      ex_imm,
    input  logic [31:0]      ex_rs1,
    input  logic             br_less,
    input  logic             br_equal,
    input  logic             stall_i,
    output logic             br_unsigned,
    output logic             ex_ready,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             misalign,
    output logic             illegal_br,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] taken_count
);

    typedef enum logic [1:0] {IDLE, REDIRECT, SQUASH} state_t;

    state_t      state, state_nxt;
    logic [2:0]  cnt;
    logic        cond_taken, f3_illegal, is_jump, taken, resolve, aligned;
    logic [31:0] target;

    // Comparator select must not depend on state so the compare settles this cycle.
    assign br_unsigned = ex_funct3[2] & ex_funct3[1];

    always_comb begin
        cond_taken = 1'b0;
        f3_illegal = 1'b0;
        case (ex_funct3)
            3'b000:         cond_taken = br_equal;
            3'b001:         cond_taken = ~br_equal;
            3'b100, 3'b110: cond_taken = br_less;
            3'b101, 3'b111: cond_taken = ~br_less;
            default:        f3_illegal = 1'b1;
        endcase
    end

    // JALR wins over JAL wins over branch when several type bits are set.
    assign is_jump = ex_is_jal | ex_is_jalr;
    assign taken   = is_jump | (ex_is_branch & cond_taken);
    assign target  = ex_is_jalr ? ((ex_rs1 + ex_imm) & ~32'd1) : (ex_pc + ex_imm);
    assign aligned = (target[1:0] == 2'b00);
    assign resolve = ex_valid & ex_ready & ~stall_i & (ex_is_branch | is_jump);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (resolve && taken && aligned) state_nxt = REDIRECT;
            REDIRECT: if (!stall_i) state_nxt = (SQUASH_CYC == 0) ? IDLE : SQUASH;
            SQUASH:   if (!stall_i && cnt == 3'd1) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ex_ready       = (state == IDLE);
        redirect_valid = (state == REDIRECT);
        flush_if_id    = (state != IDLE);
        flush_id_ex    = (state != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= 3'd0;
            redirect_pc <= 32'd0;
        end else begin
            if (state == REDIRECT && !stall_i) cnt <= 3'(SQUASH_CYC);
            else if (state == SQUASH && !stall_i) cnt <= cnt - 3'd1;
            if (state == IDLE && state_nxt == REDIRECT) redirect_pc <= target;
        end
    end

    // Misaligned taken targets still count as taken but never redirect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign    <= 1'b0;
            illegal_br  <= 1'b0;
            br_count    <= '0;
            taken_count <= '0;
        end else begin
            misalign   <= resolve & taken & ~aligned;
            illegal_br <= resolve & ~is_jump & f3_illegal;
            if (resolve && !is_jump && !f3_illegal && br_count != '1)
                br_count <= br_count + CNT_W'(1);
            if (resolve && taken && taken_count != '1)
                taken_count <= taken_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_branch_resolve.sv
// Randomized + directed bench for branch_resolve: two instances (different squash window and
// counter width) share the stimulus and are checked against a per-instance behavioural model.
module tb_branch_resolve;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex_valid, ex_is_branch, ex_is_jal, ex_is_jalr;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_pc, ex_imm, ex_rs1;
    logic        br_less, br_equal, stall_i;

    logic        a_bu, a_rdy, a_rv, a_fi, a_fe, a_mis, a_ill;
    logic [31:0] a_rpc;
    logic [15:0] a_brc, a_tkc;
    logic        b_bu, b_rdy, b_rv, b_fi, b_fe, b_mis, b_ill;
    logic [31:0] b_rpc;
    logic [3:0]  b_brc, b_tkc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    branch_resolve #(.SQUASH_CYC(1), .CNT_W(16)) u_a (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_is_branch(ex_is_branch),
        .ex_is_jal(ex_is_jal), .ex_is_jalr(ex_is_jalr), .ex_funct3(ex_funct3), .ex_pc(ex_pc),
        .ex_imm(ex_imm), .ex_rs1(ex_rs1), .br_less(br_less), .br_equal(br_equal),
        .stall_i(stall_i), .br_unsigned(a_bu), .ex_ready(a_rdy), .redirect_valid(a_rv),
        .redirect_pc(a_rpc), .flush_if_id(a_fi), .flush_id_ex(a_fe), .misalign(a_mis),
        .illegal_br(a_ill), .br_count(a_brc), .taken_count(a_tkc));

    branch_resolve #(.SQUASH_CYC(3), .CNT_W(4)) u_b (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_is_branch(ex_is_branch),
        .ex_is_jal(ex_is_jal), .ex_is_jalr(ex_is_jalr), .ex_funct3(ex_funct3), .ex_pc(ex_pc),
        .ex_imm(ex_imm), .ex_rs1(ex_rs1), .br_less(br_less), .br_equal(br_equal),
        .stall_i(stall_i), .br_unsigned(b_bu), .ex_ready(b_rdy), .redirect_valid(b_rv),
        .redirect_pc(b_rpc), .flush_if_id(b_fi), .flush_id_ex(b_fe), .misalign(b_mis),
        .illegal_br(b_ill), .br_count(b_brc), .taken_count(b_tkc));

    // Model: pending redirect flag, remaining squash cycles, last target, pulses, counts.
    int unsigned sq_len[2]  = '{1, 3};
    int unsigned cnt_max[2] = '{65535, 15};
    bit          m_rv[2];
    int unsigned m_sq[2];
    logic [31:0] m_pc[2];
    bit          m_mis[2], m_ill[2];
    int unsigned m_br[2], m_tk[2];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        logic [31:0] tgt;
        bit          tk;
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                m_rv[i] = 0; m_sq[i] = 0; m_pc[i] = 0; m_mis[i] = 0; m_ill[i] = 0;
                m_br[i] = 0; m_tk[i] = 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                m_mis[i] = 0;
                m_ill[i] = 0;
                if (m_rv[i]) begin
                    if (!stall_i) begin m_rv[i] = 0; m_sq[i] = sq_len[i]; end
                end else if (m_sq[i] > 0) begin
                    if (!stall_i) m_sq[i] = m_sq[i] - 1;
                end else if (ex_valid && !stall_i && (ex_is_branch || ex_is_jal || ex_is_jalr)) begin
                    tk = 1;
                    if (ex_is_jalr) tgt = (ex_rs1 + ex_imm) & 32'hFFFF_FFFE;
                    else begin
                        tgt = ex_pc + ex_imm;
                        if (!ex_is_jal) begin
                            case (ex_funct3)
                                3'd0: tk = br_equal;
                                3'd1: tk = !br_equal;
                                3'd4, 3'd6: tk = br_less;
                                3'd5, 3'd7: tk = !br_less;
                                default: begin tk = 0; m_ill[i] = 1; end
                            endcase
                            if (!m_ill[i] && m_br[i] < cnt_max[i]) m_br[i]++;
                        end
                    end
                    if (tk) begin
                        if (m_tk[i] < cnt_max[i]) m_tk[i]++;
                        if (tgt % 4 != 0) m_mis[i] = 1;
                        else begin m_rv[i] = 1; m_pc[i] = tgt; end
                    end
                end
            end
        end
    end

    task automatic cmp_inst(input int i, input logic bu, rdy, rv, input logic [31:0] rpc,
                            input logic fi, fe, mis, ill, input logic [31:0] brc, tkc);
        bit busy;
        busy = m_rv[i] || (m_sq[i] != 0);
        chk($sformatf("br_unsigned[%0d]", i), 32'(bu), 32'(ex_funct3 == 3'd6 || ex_funct3 == 3'd7));
        chk($sformatf("ex_ready[%0d]", i), 32'(rdy), 32'(!busy));
        chk($sformatf("redirect_valid[%0d]", i), 32'(rv), 32'(m_rv[i]));
        if (m_rv[i]) chk($sformatf("redirect_pc[%0d]", i), rpc, m_pc[i]);
        chk($sformatf("flush_if_id[%0d]", i), 32'(fi), 32'(busy));
        chk($sformatf("flush_id_ex[%0d]", i), 32'(fe), 32'(busy));
        chk($sformatf("misalign[%0d]", i), 32'(mis), 32'(m_mis[i]));
        chk($sformatf("illegal_br[%0d]", i), 32'(ill), 32'(m_ill[i]));
        chk($sformatf("br_count[%0d]", i), brc, m_br[i]);
        chk($sformatf("taken_count[%0d]", i), tkc, m_tk[i]);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            cmp_inst(0, a_bu, a_rdy, a_rv, a_rpc, a_fi, a_fe, a_mis, a_ill, 32'(a_brc), 32'(a_tkc));
            cmp_inst(1, b_bu, b_rdy, b_rv, b_rpc, b_fi, b_fe, b_mis, b_ill, 32'(b_brc), 32'(b_tkc));
        end
    end

    task automatic set_in(input bit v, b, j, jr, input logic [2:0] f3,
                          input logic [31:0] pc, imm, rs1, input bit lt, eq, st);
        ex_valid = v; ex_is_branch = b; ex_is_jal = j; ex_is_jalr = jr; ex_funct3 = f3;
        ex_pc = pc; ex_imm = imm; ex_rs1 = rs1; br_less = lt; br_equal = eq; stall_i = st;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet(input int n);
        ex_valid = 0;
        stall_i  = 0;
        repeat (n) step();
    endtask

    initial begin
        set_in(0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 0, 0);
        #22 rst = 0;
        step();
        chk("rst_ready", 32'(a_rdy), 1);
        chk("rst_redirect", 32'(a_rv), 0);
        chk("rst_flush", 32'(a_fi), 0);
        chk("rst_brc", 32'(a_brc), 0);
        chk("rst_tkc", 32'(b_tkc), 0);

        // BEQ taken
        set_in(1, 1, 0, 0, 3'b000, 32'h100, 32'h20, 0, 0, 1, 0);
        #1 chk("beq_bu", 32'(a_bu), 0);
        step(); ex_valid = 0;
        chk("beq_rv", 32'(a_rv), 1);
        chk("beq_rpc", a_rpc, 32'h120);
        chk("beq_fi", 32'(a_fi), 1);
        chk("beq_fe", 32'(a_fe), 1);
        step();
        chk("beq_sq_fi", 32'(a_fi), 1);
        chk("beq_sq_rv", 32'(a_rv), 0);
        step();
        chk("beq_ready", 32'(a_rdy), 1);
        chk("beq_brc", 32'(a_brc), 1);
        chk("beq_tkc", 32'(a_tkc), 1);
        quiet(6);

        // BGEU not taken, then taken
        set_in(1, 1, 0, 0, 3'b111, 32'h200, 32'h10, 0, 1, 0, 0);
        #1 chk("bgeu_bu", 32'(a_bu), 1);
        step(); ex_valid = 0;
        chk("bgeu_nt_rv", 32'(a_rv), 0);
        chk("bgeu_nt_brc", 32'(a_brc), 2);
        chk("bgeu_nt_tkc", 32'(a_tkc), 1);
        quiet(2);
        set_in(1, 1, 0, 0, 3'b111, 32'h200, 32'h10, 0, 0, 0, 0);
        step(); ex_valid = 0;
        chk("bgeu_t_rv", 32'(a_rv), 1);
        chk("bgeu_t_rpc", a_rpc, 32'h210);
        quiet(6);

        // JALR misaligned, then aligned
        set_in(1, 0, 0, 1, 3'd0, 32'h300, 32'h4, 32'h2003, 0, 0, 0);
        step(); ex_valid = 0;
        chk("jalr_mis", 32'(a_mis), 1);
        chk("jalr_mis_rv", 32'(a_rv), 0);
        chk("jalr_mis_tkc", 32'(a_tkc), 3);
        step();
        chk("jalr_mis_pulse", 32'(a_mis), 0);
        set_in(1, 0, 0, 1, 3'd0, 32'h300, 32'h4, 32'h2001, 0, 0, 0);
        step(); ex_valid = 0;
        chk("jalr_rv", 32'(a_rv), 1);
        chk("jalr_rpc", a_rpc, 32'h2004);
        quiet(6);

        // BNE taken, redirect held under stall, wrong-path instr ignored in squash
        set_in(1, 1, 0, 0, 3'b001, 32'h400, 32'h40, 0, 0, 0, 0);
        step(); ex_valid = 0; stall_i = 1;
        for (int k = 0; k < 3; k++) begin
            chk("stall_rv", 32'(a_rv), 1);
            chk("stall_rpc", a_rpc, 32'h440);
            step();
        end
        stall_i = 0;
        chk("stall_still_rv", 32'(a_rv), 1);
        step();
        chk("sq_rv", 32'(a_rv), 0);
        chk("sq_fi", 32'(a_fi), 1);
        set_in(1, 0, 1, 0, 3'd0, 32'h500, 32'h8, 0, 0, 0, 0);
        step(); ex_valid = 0;
        chk("sq_ignored_tkc", 32'(a_tkc), 5);
        chk("sq_ready", 32'(a_rdy), 1);
        quiet(6);

        // Illegal funct3
        set_in(1, 1, 0, 0, 3'b010, 32'h600, 32'h8, 0, 0, 1, 0);
        step(); ex_valid = 0;
        chk("ill_pulse", 32'(a_ill), 1);
        chk("ill_brc", 32'(a_brc), 4);
        step();
        chk("ill_clear", 32'(a_ill), 0);

        // Target wrap-around
        set_in(1, 0, 1, 0, 3'd0, 32'hFFFF_FFF0, 32'h20, 0, 0, 0, 0);
        step(); ex_valid = 0;
        chk("wrap_rpc", a_rpc, 32'h10);
        quiet(6);

        // Saturation on the 4-bit instance
        for (int k = 0; k < 20; k++) begin
            set_in(1, 0, 1, 0, 3'd0, 32'h1000, 32'h8, 0, 0, 0, 0);
            step();
            quiet(6);
        end
        chk("sat_b_tkc", 32'(b_tkc), 15);
        chk("sat_a_tkc", 32'(a_tkc), 26);

        // Randomized phase
        for (int n = 0; n < 4000; n++) begin
            ex_valid     = ($urandom_range(9) < 7);
            ex_is_branch = ($urandom_range(9) < 6);
            ex_is_jal    = ($urandom_range(9) < 2);
            ex_is_jalr   = ($urandom_range(9) < 2);
            ex_funct3    = 3'($urandom);
            ex_pc        = ($urandom_range(7) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            ex_imm       = ($urandom_range(7) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            ex_rs1       = $urandom;
            br_less      = 1'($urandom);
            br_equal     = 1'($urandom);
            stall_i      = ($urandom_range(3) == 0);
            step();
        end
        quiet(6);

        // Async reset in the middle of a redirect
        set_in(1, 0, 1, 0, 3'd0, 32'h800, 32'h10, 0, 0, 0, 0);
        step(); ex_valid = 0; stall_i = 1;
        chk("pre_rst_rv", 32'(a_rv), 1);
        #2 rst = 1;
        #1;
        chk("arst_a_rv", 32'(a_rv), 0);
        chk("arst_a_fi", 32'(a_fi), 0);
        chk("arst_a_tkc", 32'(a_tkc), 0);
        chk("arst_b_rv", 32'(b_rv), 0);
        chk("arst_b_brc", 32'(b_brc), 0);
        @(posedge clk);
        #3 rst = 0; stall_i = 0;
        step();
        chk("post_rst_ready", 32'(a_rdy), 1);
        chk("post_rst_rv", 32'(a_rv), 0);
        chk("post_rst_b_ready", 32'(b_rdy), 1);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
